// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and an AUX unit,
// tracking AUX destinations in a busy scoreboard. Define WBARB_STAT_EN for the force_cnt statistic.
module regfile_wb_arbiter #(
   parameter int n            = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wb_we,
   input  logic [4:0]   wb_rd,
   input  logic [n-1:0] wb_data,
   input  logic         aux_valid,
   input  logic [4:0]   aux_rd,
   input  logic [n-1:0] aux_data,
   output logic         aux_ready,
   input  logic         iss_valid,
   input  logic [4:0]   iss_rd,
   output logic         iss_ready,
   input  logic [4:0]   chk_rs1,
   input  logic [4:0]   chk_rs2,
   output logic         hazard,
   output logic         stall_pipe,
   output logic [31:0]  busy_vec,
   output logic         RegWrite,
   output logic [4:0]   WriteReg,
   output logic [n-1:0] WriteData
`ifdef WBARB_STAT_EN
   ,
   output logic [15:0]  force_cnt
`endif
);

   typedef enum logic [1:0] {ARB, FORCE, DRAIN} state_e;

   state_e         state_q, state_d;
   logic [3:0]     starve_cnt_q, starve_cnt_d;
   logic [31:0]    busy_q, busy_d;
   logic           hold_valid_q, hold_valid_d;
   logic [4:0]     hold_rd_q, hold_rd_d;
   logic [n-1:0]   hold_data_q, hold_data_d;

   logic           commit;
   logic [4:0]     commit_rd;
   logic [n-1:0]   commit_data;
   logic           aux_accept;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      commit       = 1'b0;
      commit_rd    = 5'd0;
      commit_data  = '0;
      aux_accept   = 1'b0;
      case (state_q)
         ARB: begin
            if (wb_we) begin
               commit      = 1'b1;
               commit_rd   = wb_rd;
               commit_data = wb_data;
               if (aux_valid) begin
                  if (starve_cnt_q == 4'(STARVE_LIMIT - 1)) begin
                     state_d = FORCE;
                  end else begin
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  end
               end
            end else if (aux_valid) begin
               commit       = 1'b1;
               commit_rd    = aux_rd;
               commit_data  = aux_data;
               aux_accept   = 1'b1;
               starve_cnt_d = 4'd0;
            end
         end
         FORCE: begin
            starve_cnt_d = 4'd0;
            state_d      = ARB;
            if (aux_valid) begin
               commit      = 1'b1;
               commit_rd   = aux_rd;
               commit_data = aux_data;
               aux_accept  = 1'b1;
               // The WB already in flight cannot be stopped, so park it for one cycle.
               if (wb_we) begin
                  hold_valid_d = 1'b1;
                  hold_rd_d    = wb_rd;
                  hold_data_d  = wb_data;
                  state_d      = DRAIN;
               end
            end else if (wb_we) begin
               commit      = 1'b1;
               commit_rd   = wb_rd;
               commit_data = wb_data;
            end
         end
         DRAIN: begin
            commit       = hold_valid_q;
            commit_rd    = hold_rd_q;
            commit_data  = hold_data_q;
            hold_valid_d = 1'b0;
            state_d      = ARB;
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   assign iss_ready = rst && ((iss_rd == 5'd0) || !busy_q[iss_rd]);

   always_comb begin
      busy_d = busy_q;
      if (aux_accept) begin
         busy_d[aux_rd] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_rd != 5'd0)) begin
         busy_d[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB;
         starve_cnt_q <= 4'd0;
         busy_q       <= 32'd0;
         hold_valid_q <= 1'b0;
         hold_rd_q    <= 5'd0;
         hold_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         busy_q       <= busy_d;
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
      end
   end

   // Writes to x0 still complete the handshake but never reach the register file.
   assign RegWrite   = rst && commit && (commit_rd != 5'd0);
   assign WriteReg   = commit_rd;
   assign WriteData  = commit_data;
   assign aux_ready  = rst && aux_accept;
   assign stall_pipe = (state_q != ARB);
   assign busy_vec   = busy_q;
   assign hazard     = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
                       ((chk_rs2 != 5'd0) && busy_q[chk_rs2]);

`ifdef WBARB_STAT_EN
   logic [15:0] force_cnt_q, force_cnt_d;

   always_comb begin
      force_cnt_d = force_cnt_q;
      if ((state_q == ARB) && (state_d == FORCE) && (force_cnt_q != 16'hFFFF)) begin
         force_cnt_d = force_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         force_cnt_q <= 16'd0;
      end else begin
         force_cnt_q <= force_cnt_d;
      end
   end

   assign force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// transaction-level model of write-port ownership, starvation and the busy scoreboard.
module tb_regfile_wb_arbiter;

   localparam int N     = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we, aux_valid, iss_valid;
   logic [4:0]    wb_rd, aux_rd, iss_rd, chk_rs1, chk_rs2;
   logic [N-1:0]  wb_data, aux_data;
   logic          aux_ready, iss_ready, hazard, stall_pipe, RegWrite;
   logic [31:0]   busy_vec;
   logic [4:0]    WriteReg;
   logic [N-1:0]  WriteData;

   regfile_wb_arbiter #(.n(N), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data), .aux_ready(aux_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
      .stall_pipe(stall_pipe), .busy_vec(busy_vec),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: mode 0 = normal arbitration, 1 = AUX forced, 2 = parked WB draining
   int            mMode;
   int            mBlocked;
   bit            mBusy[32];
   bit            mHoldPending;
   logic [4:0]    mHoldRd;
   logic [31:0]   mHoldData;

   bit            lastAuxAccepted;
   logic          capRegWrite, capAuxReady, capStall, capHazard, capIssReady;
   logic [4:0]    capWriteReg;
   logic [31:0]   capWriteData, capBusy;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelBusyVec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) v[i] = mBusy[i];
      return v;
   endfunction

   task automatic idleInputs();
      wb_we = 0; wb_rd = 0; wb_data = 0;
      aux_valid = 0; aux_rd = 0; aux_data = 0;
      iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 0;
      wb_we = 1; wb_rd = 5; wb_data = 32'h11;
      aux_valid = 1; aux_rd = 6; aux_data = 32'h22;
      iss_valid = 1; iss_rd = 3; chk_rs1 = 3; chk_rs2 = 7;
      #1;
      checkOutput("rst_regwrite", RegWrite, 0);
      checkOutput("rst_aux_ready", aux_ready, 0);
      checkOutput("rst_iss_ready", iss_ready, 0);
      checkOutput("rst_stall", stall_pipe, 0);
      checkOutput("rst_hazard", hazard, 0);
      checkOutput("rst_busy", busy_vec, 0);
      mMode = 0; mBlocked = 0; mHoldPending = 0;
      for (int i = 0; i < 32; i++) mBusy[i] = 0;
      @(negedge clk);
      idleInputs();
      rst = 1;
   endtask

   task automatic applyStimulus(input bit we, input logic [4:0] wrd, input logic [31:0] wdata,
                                input bit av, input logic [4:0] ard, input logic [31:0] adata,
                                input bit iv, input logic [4:0] ird,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      bit          expCommit, expAuxAcc, expIssRdy, expHaz, expWrite;
      logic [4:0]  expRd;
      logic [31:0] expData;
      int          nextMode;
      @(negedge clk);
      wb_we = we; wb_rd = wrd; wb_data = wdata;
      aux_valid = av; aux_rd = ard; aux_data = adata;
      iss_valid = iss_valid; iss_valid = iv; iss_rd = ird; chk_rs1 = rs1; chk_rs2 = rs2;

      expCommit = 0; expAuxAcc = 0; expRd = 0; expData = 0; nextMode = 0;
      if (mMode == 0) begin
         if (we) begin
            expCommit = 1; expRd = wrd; expData = wdata;
            if (av) begin
               mBlocked++;
               if (mBlocked >= LIMIT) nextMode = 1;
            end
         end else if (av) begin
            expCommit = 1; expRd = ard; expData = adata; expAuxAcc = 1;
            mBlocked = 0;
         end
      end else if (mMode == 1) begin
         mBlocked = 0;
         if (av) begin
            expCommit = 1; expRd = ard; expData = adata; expAuxAcc = 1;
            if (we) begin
               mHoldPending = 1; mHoldRd = wrd; mHoldData = wdata; nextMode = 2;
            end
         end else if (we) begin
            expCommit = 1; expRd = wrd; expData = wdata;
         end
      end else begin
         expCommit = mHoldPending; expRd = mHoldRd; expData = mHoldData;
         mHoldPending = 0;
      end
      expWrite  = expCommit && (expRd != 0);
      expIssRdy = (ird == 0) || !mBusy[ird];
      expHaz    = (rs1 != 0 && mBusy[rs1]) || (rs2 != 0 && mBusy[rs2]);

      #1;
      capRegWrite = RegWrite; capWriteReg = WriteReg; capWriteData = WriteData;
      capAuxReady = aux_ready; capStall = stall_pipe; capHazard = hazard;
      capIssReady = iss_ready; capBusy = busy_vec;
      checkOutput("stall", capStall, (mMode != 0));
      checkOutput("busy_vec", capBusy, modelBusyVec());
      checkOutput("hazard", capHazard, expHaz);
      checkOutput("iss_ready", capIssReady, expIssRdy);
      checkOutput("aux_ready", capAuxReady, expAuxAcc);
      checkOutput("regwrite", capRegWrite, expWrite);
      if (expWrite) begin
         checkOutput("write_reg", capWriteReg, expRd);
         checkOutput("write_data", capWriteData, expData);
      end

      @(posedge clk);
      if (expAuxAcc) mBusy[ard] = 0;
      if (iv && expIssRdy && ird != 0) mBusy[ird] = 1;
      mMode = nextMode;
      lastAuxAccepted = expAuxAcc;
   endtask

   initial begin
      bit          auxPend;
      bit          we;
      logic [4:0]  pRd;
      logic [31:0] pData;
      rst = 1;
      idleInputs();

      // Reset and first WB
      doReset();
      applyStimulus(1, 5, 32'hA5, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t1_wb_write", capRegWrite, 1);
      checkOutput("t1_wb_reg", capWriteReg, 5);

      // Scoreboard hazard across an AUX return
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      checkOutput("t2_hazard_set", capHazard, 1);
      applyStimulus(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
      checkOutput("t2_aux_write", capWriteReg, 7);
      checkOutput("t2_aux_ready", capAuxReady, 1);
      checkOutput("t2_hazard_hold", capHazard, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      checkOutput("t2_hazard_clear", capHazard, 0);
      checkOutput("t2_busy7", capBusy[7], 0);

      // Starvation forcing with no WB in the forced cycle
      for (int i = 0; i < LIMIT; i++) begin
         applyStimulus(1, 5'(i + 1), 32'(i), 1, 10, 32'h77, 0, 0, 0, 0);
         checkOutput("t3_no_stall", capStall, 0);
      end
      applyStimulus(0, 0, 0, 1, 10, 32'h77, 0, 0, 0, 0);
      checkOutput("t3_forced", capStall, 1);
      checkOutput("t3_forced_reg", capWriteReg, 10);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3_released", capStall, 0);

      // Forced cycle with an in-flight WB parks it into DRAIN
      for (int i = 0; i < LIMIT; i++) applyStimulus(1, 1, 32'h5, 1, 9, 32'hCAFE, 0, 0, 0, 0);
      applyStimulus(1, 3, 32'hBEEF, 1, 9, 32'hCAFE, 0, 0, 0, 0);
      checkOutput("t4_force_reg", capWriteReg, 9);
      checkOutput("t4_force_data", capWriteData, 32'hCAFE);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_drain_stall", capStall, 1);
      checkOutput("t4_drain_data", capWriteData, 32'hBEEF);
      checkOutput("t4_drain_reg", capWriteReg, 3);

      // x0 handling and busy issue rejection
      applyStimulus(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t5_wb_x0", capRegWrite, 0);
      applyStimulus(0, 0, 0, 1, 0, 32'h2, 1, 0, 0, 0);
      checkOutput("t5_aux_x0_we", capRegWrite, 0);
      checkOutput("t5_aux_x0_rdy", capAuxReady, 1);
      checkOutput("t5_iss_x0", capIssReady, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      checkOutput("t5_busy_x0", capBusy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      checkOutput("t5_iss_busy", capIssReady, 0);

      // Reset while draining drops the parked write
      for (int i = 0; i < LIMIT; i++) applyStimulus(1, 2, 32'h6, 1, 12, 32'h99, 0, 0, 0, 0);
      applyStimulus(1, 4, 32'h44, 1, 12, 32'h99, 0, 0, 0, 0);
      checkOutput("t6_in_force", capStall, 1);
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t6_no_hold_write", capRegWrite, 0);

      // Random traffic honouring the AUX hold and stall protocols
      auxPend = 0;
      pRd = 0;
      pData = 0;
      for (int c = 0; c < 400; c++) begin
         if (!auxPend && ($urandom_range(0, 2) == 0)) begin
            auxPend = 1;
            pRd = 5'($urandom_range(0, 31));
            pData = $urandom;
         end
         we = (mMode != 2) && ($urandom_range(0, 9) < 7);
         applyStimulus(we, 5'($urandom_range(0, 31)), $urandom, auxPend, pRd, pData,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if (lastAuxAccepted) auxPend = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
